cstore_loader: RTL

CSTORE_LOADER -- requirements
Module: cstore_loader

---
 rtl/cstore_loader_pkg.sv | 23 ++
 rtl/cstore_loader_if.sv | 27 ++
 rtl/cstore_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cstore_loader_pkg.sv
// Shared definitions for the control-store loader and the control ROM it fills:
// default geometry, loader state encoding and the AHI reserved-bit mask.
package cstore_loader_pkg;

    localparam int CS_ADDR_WIDTH = 12;
    localparam int CS_DATA_WIDTH = 8;

    localparam logic [7:0] AHI_RSVD_MASK = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ALO  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    // An AHI byte only carries address bits; anything in the upper nibble is a framing error.
    function automatic logic ahi_valid(input logic [7:0] b);
        return (b & AHI_RSVD_MASK) == 8'h00;
    endfunction

endpackage

// File: rtl/cstore_loader_if.sv
// Byte-stream input, control-store write port and CPU status lines of the loader.
interface cstore_loader_if import cstore_loader_pkg::*; #(
    parameter int ADDR_WIDTH = CS_ADDR_WIDTH,
    parameter int DATA_WIDTH = CS_DATA_WIDTH
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  cs_stall;
    logic                  cs_we;
    logic [ADDR_WIDTH-1:0] cs_addr;
    logic [DATA_WIDTH-1:0] cs_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;

    modport slave (
        input  in_valid, in_data, cs_stall,
        output in_ready, cs_we, cs_addr, cs_data, cpu_hold, done, err
    );

    modport master (
        output in_valid, in_data, cs_stall,
        input  in_ready, cs_we, cs_addr, cs_data, cpu_hold, done, err
    );

endinterface

// File: rtl/cstore_loader.sv
// Frame parser that streams AHI/ALO/LEN/data/CSUM bytes into the control store,
// holding the CPU for the duration of a frame and checking the byte checksum.
module cstore_loader import cstore_loader_pkg::*; #(
    parameter int ADDR_WIDTH = CS_ADDR_WIDTH,
    parameter int DATA_WIDTH = CS_DATA_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    cstore_loader_if.slave bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic                  cs_we_q, cs_we_d;
    logic [ADDR_WIDTH-1:0] cs_addr_q, cs_addr_d;
    logic [DATA_WIDTH-1:0] cs_data_q, cs_data_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept_s;
    logic [7:0]            sum_next_s;

    // Only the data phase can be back-pressured by the control store.
    assign bus.in_ready = (state_q != ST_DATA) | ~bus.cs_stall;
    assign accept_s     = bus.in_valid & bus.in_ready;
    assign sum_next_s   = sum_q + bus.in_data;

    // Next-state and output computation for one accepted byte.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cs_we_d   = 1'b0;
        cs_addr_d = cs_addr_q;
        cs_data_d = cs_data_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        err_d     = err_q;
        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (ahi_valid(bus.in_data)) begin
                        err_d   = 1'b0;
                        addr_d  = ADDR_WIDTH'({bus.in_data[3:0], 8'h00});
                        sum_d   = bus.in_data;
                        hold_d  = 1'b1;
                        state_d = ST_ALO;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
                ST_ALO: begin
                    // Low byte lands in bits that AHI left cleared.
                    addr_d  = addr_q | ADDR_WIDTH'(bus.in_data);
                    sum_d   = sum_next_s;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    cnt_d   = bus.in_data;
                    sum_d   = sum_next_s;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    cs_we_d   = 1'b1;
                    cs_addr_d = addr_q;
                    cs_data_d = DATA_WIDTH'(bus.in_data);
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    sum_d     = sum_next_s;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
                ST_CSUM: begin
                    if (sum_next_s == 8'h00) begin
                        done_d = 1'b1;
                        err_d  = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs; reset abandons any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= 8'd0;
            sum_q     <= 8'd0;
            cs_we_q   <= 1'b0;
            cs_addr_q <= '0;
            cs_data_q <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            cs_we_q   <= cs_we_d;
            cs_addr_q <= cs_addr_d;
            cs_data_q <= cs_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.cs_we    = cs_we_q;
    assign bus.cs_addr  = cs_addr_q;
    assign bus.cs_data  = cs_data_q;
    assign bus.cpu_hold = hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule
